// File: rtl/button_event_decoder_pkg.sv
// Shared types and helpers for button_event_decoder.
// Holds the FSM state encoding and the counter-width sizing function.
package button_event_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_e;

  // Smallest counter width whose range exceeds every timing parameter.
  function automatic int min_cnt_w(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_event_decoder_edge_sampler.sv
// Two-flop sampler that turns a clean level into rise/fall strobes.
// Ports: clk, reset (sync, active-high), level_in -> rise, fall.
module edge_sampler (
  input  logic clk,
  input  logic reset,
  input  logic level_in,
  output logic rise,
  output logic fall
);

  logic in_q, in_d;
  logic prev_q, prev_d;

  always_comb begin
    in_d   = level_in;
    prev_d = in_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      in_q   <= in_d;
      prev_q <= prev_d;
    end
  end

  assign rise = in_q & ~prev_q;
  assign fall = ~in_q & prev_q;

endmodule

// File: rtl/button_event_decoder.sv
// Decodes a debounced button level into press/release/long/repeat pulses.
// Ports: clk, reset (sync, active-high), level_in -> press_pulse,
// release_pulse, long_press, repeat_pulse, held, double_pulse.
// Define BUTTON_EVENT_DCLICK_EN to build the double-click detector;
// otherwise double_pulse is tied low.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int LONG_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 250,
  parameter int DCLICK_CYCLES = 300,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic level_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse,
  output logic held,
  output logic double_pulse
);

  if (CNT_W < min_cnt_w(LONG_CYCLES, REPEAT_CYCLES, DCLICK_CYCLES))
  begin : g_bad_cnt_w
    $error("CNT_W too small for the cycle parameters");
  end
  if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_cycles
    $error("LONG_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  localparam logic [CNT_W-1:0] LONG_T = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_T  = CNT_W'(REPEAT_CYCLES - 1);

  logic rise, fall;

  edge_sampler u_edge (
    .clk      (clk),
    .reset    (reset),
    .level_in (level_in),
    .rise     (rise),
    .fall     (fall)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic press_q, press_d;
  logic rel_q, rel_d;
  logic long_q, long_d;
  logic rep_q, rep_d;
  logic held_q, held_d;

`ifdef BUTTON_EVENT_DCLICK_EN
  localparam logic [CNT_W-1:0] DCLICK_T = CNT_W'(DCLICK_CYCLES - 1);
  logic dbl_q, dbl_d;
  // arm_q: window open; cdbl_q: current press was itself a double-click
  logic arm_q, arm_d;
  logic cdbl_q, cdbl_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
`ifdef BUTTON_EVENT_DCLICK_EN
    dbl_d   = 1'b0;
    arm_d   = arm_q;
    cdbl_d  = cdbl_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          cnt_d   = '0;
          state_d = PRESSED;
`ifdef BUTTON_EVENT_DCLICK_EN
          dbl_d   = arm_q;
          cdbl_d  = arm_q;
          arm_d   = 1'b0;
`endif
        end
`ifdef BUTTON_EVENT_DCLICK_EN
        // The counter is idle here, so it times the window.
        else if (arm_q) begin
          if (cnt_q == DCLICK_T) begin
            arm_d = 1'b0;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`endif
      end
      PRESSED: begin
        if (fall) begin
          rel_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == LONG_T) begin
          long_d  = 1'b1;
          cnt_d   = '0;
          state_d = LONG;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LONG: begin
        if (fall) begin
          rel_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == REP_T) begin
          rep_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
`ifdef BUTTON_EVENT_DCLICK_EN
    if (rel_d) arm_d = ~cdbl_q;
`endif
    held_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
      held_q  <= held_d;
    end
  end

`ifdef BUTTON_EVENT_DCLICK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      dbl_q  <= 1'b0;
      arm_q  <= 1'b0;
      cdbl_q <= 1'b0;
    end else begin
      dbl_q  <= dbl_d;
      arm_q  <= arm_d;
      cdbl_q <= cdbl_d;
    end
  end
  assign double_pulse = dbl_q;
`else
  assign double_pulse = 1'b0;
`endif

  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_press    = long_q;
  assign repeat_pulse  = rep_q;
  assign held          = held_q;

endmodule
